// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [1:0]        id_rs_used;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              branch_taken_mem;
  logic              dmem_req;
  logic              dmem_ack;
  logic              err_clr;

  logic              pc_write_en;
  logic              stall_if_id;
  logic              stall_id_ex;
  logic              stall_ex_mem;
  logic              bubble_mem_wb;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic              mem_timeout_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs_used, ex_rd, ex_mem_read,
           branch_taken_mem, dmem_req, dmem_ack, err_clr,
    input  pc_write_en, stall_if_id, stall_id_ex, stall_ex_mem,
           bubble_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem,
           mem_timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs_used, ex_rd, ex_mem_read,
           branch_taken_mem, dmem_req, dmem_ack, err_clr,
    output pc_write_en, stall_if_id, stall_id_ex, stall_ex_mem,
           bubble_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem,
           mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipe: load-use bubbles, MEM-stage
// branch flushes, data-memory freeze with timeout error, and perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } stateT;

  // Counter only has to reach MEM_TIMEOUT-1; it holds there on the way to ERR.
  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  stateT            state, nextState;
  logic [WCW-1:0]   waitCtr, nextWaitCtr;
  logic             timeoutErr;
  logic             setErr, clrErr;
  logic             loadUse, memWait, freeze, branchEv;
  logic             pcWriteEn;
  logic             stallIfId, stallIdEx, stallExMem, bubbleMemWb;
  logic             flushIfId, flushIdEx, flushExMem;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  assign loadUse = hz.ex_mem_read && (hz.ex_rd != {REG_AW{1'b0}}) &&
                   ((hz.id_rs_used[0] && (hz.id_rs1 == hz.ex_rd)) ||
                    (hz.id_rs_used[1] && (hz.id_rs2 == hz.ex_rd)));
  assign memWait = hz.dmem_req && !hz.dmem_ack;

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    nextState   = state;
    nextWaitCtr = waitCtr;
    setErr      = 1'b0;
    clrErr      = 1'b0;
    freeze      = 1'b0;

    unique case (state)
      RUN: begin
        if (memWait) begin
          freeze      = 1'b1;
          nextState   = MEM_WAIT;
          nextWaitCtr = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ack) begin
          nextState   = RUN;
          nextWaitCtr = '0;
        end else begin
          freeze = 1'b1;
          if (waitCtr == WCW'(MEM_TIMEOUT - 1)) begin
            nextState = ERR;
            setErr    = 1'b1;
          end else begin
            nextWaitCtr = waitCtr + WCW'(1);
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
        if (hz.err_clr) begin
          nextState   = RUN;
          nextWaitCtr = '0;
          clrErr      = 1'b1;
        end
      end
      default: begin
        nextState   = RUN;
        nextWaitCtr = '0;
      end
    endcase
  end

  // Output priority: freeze over branch flush over load-use bubble.
  always_comb begin
    pcWriteEn   = 1'b1;
    stallIfId   = 1'b0;
    stallIdEx   = 1'b0;
    stallExMem  = 1'b0;
    bubbleMemWb = 1'b0;
    flushIfId   = 1'b0;
    flushIdEx   = 1'b0;
    flushExMem  = 1'b0;
    branchEv    = 1'b0;

    if (!rst) begin
      pcWriteEn = 1'b0;
    end else if (freeze) begin
      pcWriteEn   = 1'b0;
      stallIfId   = 1'b1;
      stallIdEx   = 1'b1;
      stallExMem  = 1'b1;
      bubbleMemWb = 1'b1;
    end else if (hz.branch_taken_mem) begin
      branchEv   = 1'b1;
      flushIfId  = 1'b1;
      flushIdEx  = 1'b1;
      flushExMem = 1'b1;
    end else if (loadUse) begin
      pcWriteEn = 1'b0;
      stallIfId = 1'b1;
      flushIdEx = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      waitCtr    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      state   <= nextState;
      waitCtr <= nextWaitCtr;
      if (setErr)      timeoutErr <= 1'b1;
      else if (clrErr) timeoutErr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcWriteEn && (stallCnt != {CNT_W{1'b1}}))
        stallCnt <= stallCnt + CNT_W'(1);
      if (branchEv && (flushCnt != {CNT_W{1'b1}}))
        flushCnt <= flushCnt + CNT_W'(1);
    end
  end

  assign hz.pc_write_en     = pcWriteEn;
  assign hz.stall_if_id     = stallIfId;
  assign hz.stall_id_ex     = stallIdEx;
  assign hz.stall_ex_mem    = stallExMem;
  assign hz.bubble_mem_wb   = bubbleMemWb;
  assign hz.flush_if_id     = flushIfId;
  assign hz.flush_id_ex     = flushIdEx;
  assign hz.flush_ex_mem    = flushExMem;
  assign hz.mem_timeout_err = timeoutErr;
  assign hz.stall_cnt       = stallCnt;
  assign hz.flush_cnt       = flushCnt;

endmodule
